cpu_core_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle 16-bit RISC core.
- Sequences each instruction through an FSM: FETCH, DECODE, EXEC, MEM, WB.
- Talks to external instruction and data memories through req/ack handshakes, so memories may have variable wait states.
- Holds an internal 16-entry register file and is generalised in data, PC and data-address width.

---
 rtl/cpu_core_mc_if.sv | 32 +++
 rtl/cpu_core_mc.sv | 167 ++++++++++++++++
 tb/tb_cpu_core_mc.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_core_mc_if.sv
// Instruction/data memory handshake bundle for cpu_core_mc.
// The core is the master; memories answer with ack after any number of wait cycles.
interface cpu_core_mc_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PC_W    = 6,
  parameter int unsigned DMEM_AW = 6
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [15:0]        imem_rdata;
  logic               dmem_req;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_ack;
  logic [DATA_W-1:0]  dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/cpu_core_mc.sv
// Multi-cycle 16-entry-register RISC core (FETCH/DECODE/EXEC/MEM/WB) with req/ack memories.
// Optional macro CPU_CORE_MC_ILLEGAL_TRAP_EN: opcodes D/E halt with illegal=1 instead of NOP.
module cpu_core_mc #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PC_W     = 6,
  parameter int unsigned DMEM_AW  = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  cpu_core_mc_if.master bus,
  output logic          halted,
  output logic          illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0, OP_SUB  = 4'h1, OP_AND   = 4'h2, OP_OR    = 4'h3,
    OP_ADDI  = 4'h4, OP_LW   = 4'h5, OP_SW    = 4'h6, OP_CMP   = 4'h7,
    OP_MOV   = 4'h8, OP_LI   = 4'h9, OP_J     = 4'hA, OP_JAL   = 4'hB,
    OP_JR    = 4'hC, OP_NOPD = 4'hD, OP_NOPE  = 4'hE, OP_HALT  = 4'hF
  } op_e;

  localparam int unsigned HALF = DATA_W / 2;
  localparam logic [DATA_W-1:0] CMP_EQ = '1;
  localparam logic [DATA_W-1:0] CMP_GT = {{HALF{1'b0}}, {HALF{1'b1}}};
  localparam logic [DATA_W-1:0] CMP_LT = {{HALF{1'b1}}, {HALF{1'b0}}};

  state_e             state, state_next;
  op_e                op;
  logic [15:0]        ir;
  logic [PC_W-1:0]    pc, npc, pc_inc, exec_npc;
  logic [DATA_W-1:0]  a, b, d, res, exec_res, imm4, imm8;
  logic [DMEM_AW-1:0] mem_addr, exec_addr;
  logic [DATA_W-1:0]  rf [16];
  logic [3:0]         wb_idx;
  logic               writes_reg;
`ifdef CPU_CORE_MC_ILLEGAL_TRAP_EN
  logic               illegal_q;
`endif

  assign op     = op_e'(ir[15:12]);
  assign pc_inc = pc + PC_W'(1);
  assign imm4   = DATA_W'($signed(ir[3:0]));
  assign imm8   = DATA_W'($signed(ir[7:0]));

  always_comb begin
    exec_res  = '0;
    exec_npc  = pc_inc;
    exec_addr = DMEM_AW'(a + imm4);
    case (op)
      OP_ADD:  exec_res = a + b;
      OP_SUB:  exec_res = a - b;
      OP_AND:  exec_res = a & b;
      OP_OR:   exec_res = a | b;
      OP_ADDI: exec_res = a + imm4;
      OP_CMP:  exec_res = (a == b) ? CMP_EQ : ((a > b) ? CMP_GT : CMP_LT);
      OP_MOV:  exec_res = a;
      OP_LI:   exec_res = imm8;
      OP_J:    exec_npc = ir[PC_W-1:0];
      OP_JAL: begin
        exec_res = DATA_W'(pc_inc);
        exec_npc = ir[PC_W-1:0];
      end
      OP_JR:   exec_npc = PC_W'(a);
      default: ;
    endcase
  end

  always_comb begin
    wb_idx     = (op == OP_JAL) ? 4'd15 : ir[11:8];
    writes_reg = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LW,
      OP_CMP, OP_MOV, OP_LI, OP_JAL: writes_reg = 1'b1;
      default: writes_reg = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (bus.imem_ack) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEM;
          OP_HALT:      state_next = S_HALT;
`ifdef CPU_CORE_MC_ILLEGAL_TRAP_EN
          OP_NOPD, OP_NOPE: state_next = S_HALT;
`endif
          default:      state_next = S_WB;
        endcase
      end
      S_MEM:    if (bus.dmem_ack) state_next = S_WB;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req   = (state == S_FETCH);
    bus.imem_addr  = pc;
    bus.dmem_req   = (state == S_MEM);
    bus.dmem_we    = (state == S_MEM) && (op == OP_SW);
    bus.dmem_addr  = (state == S_MEM) ? mem_addr : '0;
    bus.dmem_wdata = ((state == S_MEM) && (op == OP_SW)) ? d : '0;
    halted         = (state == S_HALT);
`ifdef CPU_CORE_MC_ILLEGAL_TRAP_EN
    illegal        = (state == S_HALT) && illegal_q;
`else
    illegal        = 1'b0;
`endif
  end

  // pc only advances in WB, so a halt or trap leaves it on the stopping instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= PC_W'(RESET_PC);
      npc      <= '0;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      d        <= '0;
      res      <= '0;
      mem_addr <= '0;
`ifdef CPU_CORE_MC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
      for (int unsigned i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH:  if (bus.imem_ack) ir <= bus.imem_rdata;
        S_DECODE: begin
          a <= rf[ir[7:4]];
          b <= rf[ir[3:0]];
          d <= rf[ir[11:8]];
        end
        S_EXEC: begin
          res      <= exec_res;
          npc      <= exec_npc;
          mem_addr <= exec_addr;
`ifdef CPU_CORE_MC_ILLEGAL_TRAP_EN
          if (op == OP_NOPD || op == OP_NOPE) illegal_q <= 1'b1;
`endif
        end
        S_MEM: if (bus.dmem_ack && op == OP_LW) res <= bus.dmem_rdata;
        S_WB: begin
          if (writes_reg) rf[wb_idx] <= res;
          pc <= npc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Self-checking bench for cpu_core_mc: directed scenarios plus random programs vs an ISA-level model.
module tb_cpu_core_mc;
  localparam int DW     = 16;
  localparam int PW     = 6;
  localparam int AW     = 6;
  localparam int IMEM_N = 1 << PW;
  localparam int DMEM_N = 1 << AW;
  localparam int MASK   = (1 << DW) - 1;
`ifdef CPU_CORE_MC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halted, illegal;

  cpu_core_mc_if #(.DATA_W(DW), .PC_W(PW), .DMEM_AW(AW)) bus ();

  cpu_core_mc #(.DATA_W(DW), .PC_W(PW), .DMEM_AW(AW), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  logic [15:0]   imem [IMEM_N];
  logic [DW-1:0] dmem [DMEM_N];
  int  imem_wait_fixed = 0;
  int  dmem_wait_fixed = 0;
  bit  rand_waits = 0;
  bit  spurious   = 0;
  int  n_checks = 0;
  int  n_fail   = 0;
  acc_t dlog[$];
  int   dlen_log[$];
  int   fetch_log[$];
  int   dunstable = 0;

  logic [DW-1:0] m_rf [16];
  logic [DW-1:0] m_dmem [DMEM_N];
  int   m_pc;
  bit   m_ill;
  acc_t m_acc[$];

  function automatic int pick(input int fixed);
    return rand_waits ? int'($urandom_range(0, 3)) : fixed;
  endfunction

  // instruction memory responder
  initial begin
    int  iwait;
    bit  ibusy;
    iwait = 0;
    ibusy = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_req) begin
        if (!ibusy) begin
          ibusy = 1;
          iwait = pick(imem_wait_fixed);
        end
        if (iwait == 0) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = imem[bus.imem_addr];
          fetch_log.push_back(int'(bus.imem_addr));
          ibusy = 0;
        end else begin
          bus.imem_ack = 1'b0;
          iwait--;
        end
      end else begin
        ibusy = 0;
        bus.imem_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.imem_rdata = 16'($urandom);
      end
    end
  end

  // data memory responder; also watches request stability across wait cycles
  initial begin
    int   dwait, dlen;
    bit   dbusy;
    acc_t first, e;
    dwait = 0;
    dlen  = 0;
    dbusy = 0;
    first = '0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.dmem_req) begin
        if (!dbusy) begin
          dbusy = 1;
          dwait = pick(dmem_wait_fixed);
          dlen  = 0;
          first.we   = bus.dmem_we;
          first.addr = bus.dmem_addr;
          first.data = bus.dmem_wdata;
        end else if (bus.dmem_we !== first.we || bus.dmem_addr !== first.addr ||
                     (first.we && bus.dmem_wdata !== first.data)) begin
          dunstable++;
        end
        dlen++;
        if (dwait == 0) begin
          bus.dmem_ack = 1'b1;
          e.we   = bus.dmem_we;
          e.addr = bus.dmem_addr;
          if (bus.dmem_we) begin
            dmem[bus.dmem_addr] = bus.dmem_wdata;
            e.data = bus.dmem_wdata;
          end else begin
            bus.dmem_rdata = dmem[bus.dmem_addr];
            e.data = dmem[bus.dmem_addr];
          end
          dlog.push_back(e);
          dlen_log.push_back(dlen);
          dbusy = 0;
        end else begin
          bus.dmem_ack = 1'b0;
          dwait--;
        end
      end else begin
        dbusy = 0;
        bus.dmem_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.dmem_rdata = DW'($urandom);
      end
    end
  end

  // Architectural model: executes the program in imem one whole instruction at a time.
  task automatic model_run();
    int   steps, a, b, dv, s4, s8, res, addr, nxt, op, rd, rs, rt;
    bit   done, wr;
    logic [15:0] ir;
    acc_t e;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_acc.delete();
    m_pc  = 0;
    m_ill = 0;
    done  = 0;
    steps = 0;
    while (!done && steps < 1000) begin
      ir  = imem[m_pc];
      op  = int'(ir[15:12]);
      rd  = int'(ir[11:8]);
      rs  = int'(ir[7:4]);
      rt  = int'(ir[3:0]);
      a   = int'(m_rf[rs]);
      b   = int'(m_rf[rt]);
      dv  = int'(m_rf[rd]);
      s4  = ir[3] ? int'(ir[3:0]) - 16 : int'(ir[3:0]);
      s8  = ir[7] ? int'(ir[7:0]) - 256 : int'(ir[7:0]);
      nxt = (m_pc + 1) % IMEM_N;
      addr = ((a + s4) & MASK) % DMEM_N;
      wr  = 1;
      res = 0;
      case (op)
        0:  res = (a + b) & MASK;
        1:  res = (a - b) & MASK;
        2:  res = a & b;
        3:  res = a | b;
        4:  res = (a + s4) & MASK;
        5: begin
          res = int'(m_dmem[addr]);
          e.we = 1'b0; e.addr = AW'(addr); e.data = DW'(res);
          m_acc.push_back(e);
        end
        6: begin
          wr = 0;
          m_dmem[addr] = DW'(dv);
          e.we = 1'b1; e.addr = AW'(addr); e.data = DW'(dv);
          m_acc.push_back(e);
        end
        7:  res = (a == b) ? MASK : ((a > b) ? ((1 << (DW / 2)) - 1) : (MASK ^ ((1 << (DW / 2)) - 1)));
        8:  res = a;
        9:  res = s8 & MASK;
        10: begin wr = 0; nxt = int'(ir) % IMEM_N; end
        11: begin wr = 0; m_rf[15] = DW'(nxt); nxt = int'(ir) % IMEM_N; end
        12: begin wr = 0; nxt = a % IMEM_N; end
        13, 14: begin
          wr = 0;
          if (TRAP) begin m_ill = 1; done = 1; end
        end
        default: begin wr = 0; done = 1; end
      endcase
      if (wr) m_rf[rd] = DW'(res);
      if (!done) m_pc = nxt;
      steps++;
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < IMEM_N; i++) imem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    fetch_log.delete();
    dlog.delete();
    dlen_log.delete();
    dunstable = 0;
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int cyc, output bit timeout);
    cyc = 0;
    timeout = 1;
    while (cyc < budget) begin
      @(posedge clk);
      cyc++;
      #1;
      if (halted) begin
        timeout = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [1+1+1+AW+DW+1+1-1:0] outs;
    int nz;
    @(posedge clk);
    #1;
    outs = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, halted, illegal};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %0h expected 0", outs); end
    n_checks++;
    if (dut.pc !== PW'(0)) begin n_fail++; $display("FAIL reset_pc: got %0h expected 0", dut.pc); end
    nz = 0;
    for (int i = 0; i < 16; i++) if (dut.rf[i] !== '0) nz++;
    n_checks++;
    if (nz != 0) begin n_fail++; $display("FAIL reset_regs: got %0d nonzero expected 0", nz); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: got %b expected 0", bus.imem_req); end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== PW'(0)) begin
      n_fail++; $display("FAIL first_fetch: got req=%b addr=%0h expected req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_basic_alu();
    int cyc; bit to;
    clear_imem();
    imem[0] = 16'h9105; imem[1] = 16'h92FD; imem[2] = 16'h0312; imem[3] = 16'hF000;
    imem_wait_fixed = 0; dmem_wait_fixed = 0; rand_waits = 0; spurious = 0;
    do_reset();
    run_to_halt(100, cyc, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL basic_halt_timeout: got no halt expected halt"); end
    n_checks++;
    if (cyc != 16) begin n_fail++; $display("FAIL basic_cycles: got %0d expected 16", cyc); end
    n_checks++;
    if (dut.rf[3] !== DW'('h0002)) begin n_fail++; $display("FAIL basic_r3: got %0h expected 2", dut.rf[3]); end
    n_checks++;
    if (dut.pc !== PW'(3)) begin n_fail++; $display("FAIL basic_pc: got %0h expected 3", dut.pc); end
    n_checks++;
    if (illegal !== 1'b0) begin n_fail++; $display("FAIL basic_illegal: got %b expected 0", illegal); end
  endtask

  task automatic test_mem_wait();
    int cyc; bit to;
    clear_imem();
    imem[0] = 16'h9105; imem[1] = 16'h6104; imem[2] = 16'h5404; imem[3] = 16'hF000;
    for (int i = 0; i < DMEM_N; i++) dmem[i] = '0;
    imem_wait_fixed = 0; dmem_wait_fixed = 3; rand_waits = 0; spurious = 0;
    do_reset();
    run_to_halt(200, cyc, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL mem_halt_timeout: got no halt expected halt"); end
    n_checks++;
    if (cyc != 24) begin n_fail++; $display("FAIL mem_cycles: got %0d expected 24", cyc); end
    n_checks++;
    if (dlog.size() != 2) begin n_fail++; $display("FAIL mem_access_count: got %0d expected 2", dlog.size()); end
    else begin
      n_checks++;
      if (dlog[0].we !== 1'b1 || dlog[0].addr !== AW'(4) || dlog[0].data !== DW'(5)) begin
        n_fail++; $display("FAIL sw_access: got we=%b addr=%0h data=%0h expected we=1 addr=4 data=5",
                           dlog[0].we, dlog[0].addr, dlog[0].data);
      end
      n_checks++;
      if (dlen_log[0] != 4) begin n_fail++; $display("FAIL sw_req_len: got %0d expected 4", dlen_log[0]); end
      n_checks++;
      if (dlog[1].we !== 1'b0 || dlog[1].addr !== AW'(4)) begin
        n_fail++; $display("FAIL lw_access: got we=%b addr=%0h expected we=0 addr=4", dlog[1].we, dlog[1].addr);
      end
    end
    n_checks++;
    if (dunstable != 0) begin n_fail++; $display("FAIL mem_stable: got %0d changes expected 0", dunstable); end
    n_checks++;
    if (dut.rf[4] !== DW'(5)) begin n_fail++; $display("FAIL lw_r4: got %0h expected 5", dut.rf[4]); end
  endtask

  task automatic test_cmp();
    int cyc; bit to;
    clear_imem();
    imem[0] = 16'h9110; imem[1] = 16'h9220; imem[2] = 16'h7312;
    imem[3] = 16'h7421; imem[4] = 16'h7511; imem[5] = 16'hF000;
    imem_wait_fixed = 1; dmem_wait_fixed = 0; rand_waits = 0; spurious = 0;
    do_reset();
    run_to_halt(200, cyc, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL cmp_halt_timeout: got no halt expected halt"); end
    n_checks++;
    if (dut.rf[3] !== DW'('hFF00)) begin n_fail++; $display("FAIL cmp_lt: got %0h expected ff00", dut.rf[3]); end
    n_checks++;
    if (dut.rf[4] !== DW'('h00FF)) begin n_fail++; $display("FAIL cmp_gt: got %0h expected 00ff", dut.rf[4]); end
    n_checks++;
    if (dut.rf[5] !== DW'('hFFFF)) begin n_fail++; $display("FAIL cmp_eq: got %0h expected ffff", dut.rf[5]); end
  endtask

  task automatic test_jumps();
    int exp_f[6];
    exp_f = '{0, 7, 32, 8, 63, 0};
    clear_imem();
    imem[0]  = 16'hA007;
    imem[7]  = 16'hB320;
    imem[32] = 16'hC0F0;
    imem[8]  = 16'hA03F;
    imem[63] = 16'h86F0;
    imem_wait_fixed = 0; dmem_wait_fixed = 0; rand_waits = 0; spurious = 0;
    do_reset();
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (fetch_log.size() < 6) begin n_fail++; $display("FAIL jump_fetch_count: got %0d expected >=6", fetch_log.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (fetch_log[i] != exp_f[i]) begin
          n_fail++; $display("FAIL jump_fetch_addr[%0d]: got %0h expected %0h", i, fetch_log[i], exp_f[i]);
        end
      end
    end
    n_checks++;
    if (dut.rf[15] !== DW'(8)) begin n_fail++; $display("FAIL jal_link: got %0h expected 8", dut.rf[15]); end
    n_checks++;
    if (dut.rf[3] !== '0) begin n_fail++; $display("FAIL jal_rd_ignored: got %0h expected 0", dut.rf[3]); end
    n_checks++;
    if (dut.rf[6] !== DW'(8)) begin n_fail++; $display("FAIL wrap_mov: got %0h expected 8", dut.rf[6]); end
  endtask

  task automatic test_reset_mid_fetch();
    int cyc, nz; bit to;
    clear_imem();
    imem[0] = 16'h9105; imem[1] = 16'h9207;
    imem_wait_fixed = 0; dmem_wait_fixed = 0; rand_waits = 0; spurious = 0;
    do_reset();
    repeat (2) @(posedge clk);
    imem_wait_fixed = 1000;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== PW'(1)) begin
      n_fail++; $display("FAIL stall_fetch: got req=%b addr=%0h expected req=1 addr=1", bus.imem_req, bus.imem_addr);
    end
    n_checks++;
    if (dut.rf[1] !== DW'(5)) begin n_fail++; $display("FAIL pre_reset_r1: got %0h expected 5", dut.rf[1]); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL async_drop_req: got %b expected 0", bus.imem_req); end
    n_checks++;
    if (dut.pc !== PW'(0)) begin n_fail++; $display("FAIL async_pc: got %0h expected 0", dut.pc); end
    nz = 0;
    for (int i = 0; i < 16; i++) if (dut.rf[i] !== '0) nz++;
    n_checks++;
    if (nz != 0) begin n_fail++; $display("FAIL async_regs: got %0d nonzero expected 0", nz); end
    imem_wait_fixed = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== PW'(0)) begin
      n_fail++; $display("FAIL restart_fetch: got req=%b addr=%0h expected req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
    run_to_halt(100, cyc, to);
    n_checks++;
    if (to || dut.rf[2] !== DW'(7)) begin
      n_fail++; $display("FAIL restart_run: got timeout=%b r2=%0h expected timeout=0 r2=7", to, dut.rf[2]);
    end
  endtask

  task automatic test_illegal_opcode();
    int cyc; bit to;
    clear_imem();
    imem[0] = 16'h9101; imem[1] = 16'hD123; imem[2] = 16'hF000;
    imem_wait_fixed = 0; dmem_wait_fixed = 0; rand_waits = 0; spurious = 0;
    do_reset();
    run_to_halt(100, cyc, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL illop_timeout: got no halt expected halt"); end
    n_checks++;
    if (cyc != (TRAP ? 8 : 12)) begin n_fail++; $display("FAIL illop_cycles: got %0d expected %0d", cyc, TRAP ? 8 : 12); end
    n_checks++;
    if (illegal !== TRAP) begin n_fail++; $display("FAIL illop_flag: got %b expected %b", illegal, TRAP); end
    n_checks++;
    if (dut.pc !== PW'(TRAP ? 1 : 2)) begin n_fail++; $display("FAIL illop_pc: got %0h expected %0h", dut.pc, TRAP ? 1 : 2); end
    n_checks++;
    if (dut.rf[1] !== DW'(1)) begin n_fail++; $display("FAIL illop_no_write: got %0h expected 1", dut.rf[1]); end
  endtask

  task automatic test_random_programs();
    int cyc, len, r, tgt; bit to;
    for (int p = 0; p < 8; p++) begin
      clear_imem();
      len = 40;
      for (int i = 0; i < len; i++) begin
        r = int'($urandom_range(0, 11));
        if (r == 10) begin
          tgt = int'($urandom_range(i + 1, len));
          imem[i] = {4'hA, 6'($urandom), 6'(tgt)};
        end else if (r == 11) begin
          imem[i] = {4'h9, 12'($urandom)};
        end else begin
          imem[i] = {4'(r), 12'($urandom)};
        end
      end
      for (int i = 0; i < DMEM_N; i++) begin
        dmem[i]   = DW'($urandom);
        m_dmem[i] = dmem[i];
      end
      model_run();
      rand_waits = 1; spurious = 1;
      do_reset();
      run_to_halt(3000, cyc, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL rand%0d_timeout: got no halt expected halt", p); end
      n_checks++;
      if (dut.pc !== PW'(m_pc)) begin n_fail++; $display("FAIL rand%0d_pc: got %0h expected %0h", p, dut.pc, m_pc); end
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (dut.rf[i] !== m_rf[i]) begin
          n_fail++; $display("FAIL rand%0d_r%0d: got %0h expected %0h", p, i, dut.rf[i], m_rf[i]);
        end
      end
      n_checks++;
      if (dlog.size() != m_acc.size()) begin
        n_fail++; $display("FAIL rand%0d_acc_count: got %0d expected %0d", p, dlog.size(), m_acc.size());
      end else begin
        for (int i = 0; i < dlog.size(); i++) begin
          n_checks++;
          if (dlog[i] !== m_acc[i]) begin
            n_fail++; $display("FAIL rand%0d_acc[%0d]: got %0h expected %0h", p, i, dlog[i], m_acc[i]);
          end
        end
      end
      for (int i = 0; i < DMEM_N; i++) begin
        n_checks++;
        if (dmem[i] !== m_dmem[i]) begin
          n_fail++; $display("FAIL rand%0d_mem[%0d]: got %0h expected %0h", p, i, dmem[i], m_dmem[i]);
        end
      end
      n_checks++;
      if (dunstable != 0) begin n_fail++; $display("FAIL rand%0d_stable: got %0d changes expected 0", p, dunstable); end
      n_checks++;
      if (illegal !== 1'b0) begin n_fail++; $display("FAIL rand%0d_illegal: got %b expected 0", p, illegal); end
    end
    rand_waits = 0; spurious = 0;
  endtask

  initial begin
    clear_imem();
    for (int i = 0; i < DMEM_N; i++) dmem[i] = '0;
    test_reset();
    test_basic_alu();
    test_mem_wait();
    test_cmp();
    test_jumps();
    test_reset_mid_fetch();
    test_illegal_opcode();
    test_random_programs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
